// File: rtl/jump_pkg.sv
// Shared definitions for the jump control stage: opcode encoding and default sizes.
package jump_pkg;

  localparam int DEF_D = 12;
  localparam int DEF_L = 4;
  localparam int DEF_S = 4;

  typedef enum logic [2:0] {
    JOP_NONE = 3'd0,
    JOP_JMP  = 3'd1,
    JOP_BEQ  = 3'd2,
    JOP_BNE  = 3'd3,
    JOP_CALL = 3'd4,
    JOP_RET  = 3'd5
  } jop_t;

endpackage

// File: rtl/jump_ctrl_if.sv
// Decode-to-PC bus of the jump stage. The decode side drives the opcode, operands and
// LUT write port; the jump stage returns the jump request and the stack status.
interface jump_ctrl_if #(
  parameter int D = jump_pkg::DEF_D,
  parameter int L = jump_pkg::DEF_L,
  parameter int S = jump_pkg::DEF_S
);
  import jump_pkg::*;

  jop_t                 jop;
  logic [L-1:0]         lut_idx;
  logic                 zero;
  logic [D-1:0]         prog_ctr;
  logic                 lut_we;
  logic [L-1:0]         lut_waddr;
  logic [D-1:0]         lut_wdata;
  logic                 absjump_en;
  logic [D-1:0]         target;
  logic                 ras_ovf;
  logic                 ras_unf;
  logic [$clog2(S):0]   ras_depth;

  // No handshake: absjump_en/target are a same-cycle response, sampled by the PC on the next posedge.
  modport master (
    output jop, lut_idx, zero, prog_ctr, lut_we, lut_waddr, lut_wdata,
    input  absjump_en, target, ras_ovf, ras_unf, ras_depth
  );

  modport slave (
    input  jop, lut_idx, zero, prog_ctr, lut_we, lut_waddr, lut_wdata,
    output absjump_en, target, ras_ovf, ras_unf, ras_depth
  );

endinterface

// File: rtl/ret_stack.sv
// Return-address stack. A push while full drops the value and a pop while empty is ignored.
module ret_stack #(
  parameter int D = 12,
  parameter int S = 4
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 push,
  input  logic                 pop,
  input  logic [D-1:0]         din,
  output logic [D-1:0]         dout,
  output logic [$clog2(S):0]   depth,
  output logic                 full,
  output logic                 empty
);

  localparam int AW = $clog2(S);

  logic [D-1:0]  mem [S];
  logic [AW:0]   sp;
  logic [AW:0]   sp_m1;

  assign sp_m1 = sp - 1'b1;
  assign full  = (sp == (AW+1)'(S));
  assign empty = (sp == '0);
  assign depth = sp;
  assign dout  = empty ? '0 : mem[sp_m1[AW-1:0]];

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      sp <= '0;
      for (int i = 0; i < S; i++) mem[i] <= '0;
    end else if (push && !full) begin
      mem[sp[AW-1:0]] <= din;
      sp              <= sp + 1'b1;
    end else if (pop && !empty) begin
      sp <= sp_m1;
    end
  end

endmodule

// File: rtl/jump_ctrl.sv
// Jump control stage: decodes the jump class, picks a LUT or return-stack target and
// raises the PC's absolute-jump enable in the same cycle.
module jump_ctrl
  import jump_pkg::*;
#(
  parameter int D = DEF_D,
  parameter int L = DEF_L,
  parameter int S = DEF_S
) (
  input  logic       clk,
  input  logic       reset,
  jump_ctrl_if.slave bus
);

  logic [D-1:0]  lut [2**L];
  logic [D-1:0]  lut_rd;
  logic [D-1:0]  ret_addr;
  logic          st_full;
  logic          st_empty;
  logic          is_call;
  logic          is_ret;
  logic          ovf_q;
  logic          unf_q;
  logic          en_c;
  logic [D-1:0]  tgt_c;

  assign lut_rd  = lut[bus.lut_idx];
  assign is_call = (bus.jop == JOP_CALL);
  assign is_ret  = (bus.jop == JOP_RET);

  ret_stack #(.D(D), .S(S)) u_ret_stack (
    .clk   (clk),
    .reset (reset),
    .push  (is_call),
    .pop   (is_ret),
    .din   (bus.prog_ctr + 1'b1),
    .dout  (ret_addr),
    .depth (bus.ras_depth),
    .full  (st_full),
    .empty (st_empty)
  );

  // LUT reads see the pre-write value; a write lands on the edge.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      for (int i = 0; i < 2**L; i++) lut[i] <= '0;
    end else if (bus.lut_we) begin
      lut[bus.lut_waddr] <= bus.lut_wdata;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      ovf_q <= 1'b0;
      unf_q <= 1'b0;
    end else begin
      if (is_call && st_full) ovf_q <= 1'b1;
      if (is_ret && st_empty) unf_q <= 1'b1;
    end
  end

  always_comb begin
    en_c  = 1'b0;
    tgt_c = '0;
    case (bus.jop)
      JOP_JMP, JOP_CALL: begin
        en_c  = 1'b1;
        tgt_c = lut_rd;
      end
      JOP_BEQ: begin
        en_c  = bus.zero;
        tgt_c = lut_rd;
      end
      JOP_BNE: begin
        en_c  = ~bus.zero;
        tgt_c = lut_rd;
      end
      JOP_RET: begin
        en_c  = ~st_empty;
        tgt_c = st_empty ? '0 : ret_addr;
      end
      default: begin
        en_c  = 1'b0;
        tgt_c = '0;
      end
    endcase
  end

  assign bus.absjump_en = reset ? 1'b0 : en_c;
  assign bus.target     = reset ? '0 : tgt_c;
  assign bus.ras_ovf    = ovf_q;
  assign bus.ras_unf    = unf_q;

endmodule

// File: tb/tb_jump_ctrl.sv
// Directed bench for jump_ctrl: LUT write/read timing, branch decode, return stack
// ordering, overflow/underflow flags, PC wrap and asynchronous reset.
module tb_jump_ctrl;
  import jump_pkg::*;

  localparam int D = 12;
  localparam int L = 4;
  localparam int S = 4;

  logic clk;
  logic reset;
  int   total;
  int   bad;

  jump_ctrl_if #(.D(D), .L(L), .S(S)) bus ();

  jump_ctrl #(.D(D), .L(L), .S(S)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus.slave)
  );

  // clock / reset
  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got=0x%0h expected=0x%0h", tag, got, exp);
    end
  endtask

  // driver tasks: inputs change #1 after posedge, checks happen mid-cycle
  task automatic drive(input logic [2:0] op, input logic [L-1:0] idx, input logic z,
                       input logic [D-1:0] pc);
    bus.jop      = jop_t'(op);
    bus.lut_idx  = idx;
    bus.zero     = z;
    bus.prog_ctr = pc;
    #2;
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
    bus.lut_we = 1'b0;
  endtask

  task automatic check_out(input string tag, input logic en, input logic [D-1:0] tgt);
    check({tag, ".en"}, 32'(bus.absjump_en), 32'(en));
    check({tag, ".tgt"}, 32'(bus.target), 32'(tgt));
  endtask

  logic [D-1:0] ret_exp [4];

  initial begin
    total = 0;
    bad   = 0;
    reset = 1'b1;
    bus.jop = JOP_NONE; bus.lut_idx = '0; bus.zero = 1'b0; bus.prog_ctr = '0;
    bus.lut_we = 1'b0; bus.lut_waddr = '0; bus.lut_wdata = '0;
    ret_exp[0] = 12'h005; ret_exp[1] = 12'h004; ret_exp[2] = 12'h003; ret_exp[3] = 12'h002;

    @(posedge clk); #1;
    drive(3'd1, 4'd3, 1'b0, 12'h000);
    check_out("rst_jmp", 1'b0, 12'h000);
    check("rst_depth", 32'(bus.ras_depth), 0);
    check("rst_ovf", 32'(bus.ras_ovf), 0);
    check("rst_unf", 32'(bus.ras_unf), 0);
    #2 reset = 1'b0;
    tick();

    // write idx3 while jumping through it: old value seen this cycle
    bus.lut_we = 1'b1; bus.lut_waddr = 4'd3; bus.lut_wdata = 12'h0A5;
    drive(3'd1, 4'd3, 1'b0, 12'h000);
    check_out("jmp_same", 1'b1, 12'h000);
    tick();
    drive(3'd1, 4'd3, 1'b0, 12'h000);
    check_out("jmp_next", 1'b1, 12'h0A5);

    drive(3'd2, 4'd3, 1'b1, 12'h000); check_out("beq_z1", 1'b1, 12'h0A5);
    drive(3'd2, 4'd3, 1'b0, 12'h000); check("beq_z0.en", 32'(bus.absjump_en), 0);
    drive(3'd3, 4'd3, 1'b1, 12'h000); check("bne_z1.en", 32'(bus.absjump_en), 0);
    drive(3'd3, 4'd3, 1'b0, 12'h000); check_out("bne_z0", 1'b1, 12'h0A5);
    drive(3'd0, 4'd3, 1'b0, 12'h000); check_out("none", 1'b0, 12'h000);
    drive(3'd6, 4'd3, 1'b0, 12'h000); check_out("rsvd6", 1'b0, 12'h000);
    drive(3'd7, 4'd3, 1'b1, 12'h000); check_out("rsvd7", 1'b0, 12'h000);

    // single call / return
    drive(3'd4, 4'd3, 1'b0, 12'h010);
    check_out("call1", 1'b1, 12'h0A5);
    tick();
    check("call1_depth", 32'(bus.ras_depth), 1);
    drive(3'd5, 4'd0, 1'b0, 12'h0A5);
    check_out("ret1", 1'b1, 12'h011);
    tick();
    check("ret1_depth", 32'(bus.ras_depth), 0);

    // five calls overflow a 4-deep stack
    for (int i = 1; i <= 5; i++) begin
      drive(3'd4, 4'd3, 1'b0, D'(i));
      check_out($sformatf("callx%0d", i), 1'b1, 12'h0A5);
      tick();
    end
    check("ovf_depth", 32'(bus.ras_depth), 4);
    check("ovf_flag", 32'(bus.ras_ovf), 1);
    for (int i = 0; i < 4; i++) begin
      drive(3'd5, 4'd0, 1'b0, 12'h0A5);
      check_out($sformatf("retx%0d", i), 1'b1, ret_exp[i]);
      tick();
    end
    check("drain_depth", 32'(bus.ras_depth), 0);

    // underflow
    drive(3'd5, 4'd0, 1'b0, 12'h0A5);
    check_out("ret_empty", 1'b0, 12'h000);
    tick();
    check("unf_flag", 32'(bus.ras_unf), 1);
    check("unf_depth", 32'(bus.ras_depth), 0);
    check("ovf_sticky", 32'(bus.ras_ovf), 1);

    // return address wraps at the top of the PC range
    drive(3'd4, 4'd3, 1'b0, 12'hFFF);
    tick();
    drive(3'd5, 4'd0, 1'b0, 12'h0A5);
    check_out("ret_wrap", 1'b1, 12'h000);
    tick();
    check("unf_sticky", 32'(bus.ras_unf), 1);

    // async reset mid-cycle after two calls
    drive(3'd4, 4'd3, 1'b0, 12'h020); tick();
    drive(3'd4, 4'd3, 1'b0, 12'h030); tick();
    check("pre_rst_depth", 32'(bus.ras_depth), 2);
    drive(3'd1, 4'd3, 1'b0, 12'h000);
    reset = 1'b1;
    #1;
    check("arst_depth", 32'(bus.ras_depth), 0);
    check("arst_ovf", 32'(bus.ras_ovf), 0);
    check("arst_unf", 32'(bus.ras_unf), 0);
    check_out("arst_jmp", 1'b0, 12'h000);
    tick();
    reset = 1'b0;
    #1;
    check_out("post_rst_lut", 1'b1, 12'h000);
    drive(3'd5, 4'd0, 1'b0, 12'h000);
    check_out("post_rst_ret", 1'b0, 12'h000);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #20000;
    $display("FAIL watchdog: got=timeout expected=finish");
    $fatal(1, "watchdog expired");
  end

endmodule
